avr_pp_sequencer: RTL
=====================

AVR_PP_SEQUENCER -- requirements
Module: avr_pp_sequencer

Interface
REQ-001 Parameters: XTAL_PULSE, default 4, dut_xtal high time in clk cycles (1..255).
REQ-002 Parameters: WR_PULSE, default 8, dut_wr low time in clk cycles (1..255).
REQ-003 Parameters: OE_SETTLE, default 4, dut_oe low time before data sample in clk cycles (1..255).
REQ-004 Parameters: RDY_TIMEOUT, default 65535, maximum WAIT_RDY cycles (16 bit).
REQ-005 Ports: clk  in  1  single clock; all state changes on rising edge.
REQ-006 Ports: rst  in  1  synchronous reset, active-high.
REQ-007 Ports: cmd_valid  in  1 / cmd_ready  out  1  command handshake; transfer on an edge with both high.
REQ-008 Ports: cmd_op  in  3  operation code / cmd_data  in  8  operand byte.
REQ-009 Ports: rsp_valid  out  1  one-cycle completion pulse / rsp_data  out  8  read result / error  out  1  sticky timeout flag / busy  out  1.
REQ-010 Ports: dut_xtal, dut_oe, dut_wr, dut_bs1, dut_bs2, dut_xa0, dut_xa1, dut_pagel  out  1 each  DUT parallel-programming control pins.
REQ-011 Ports: dut_data_out  out  8 / dut_data_oe  out  1 / dut_data_in  in  8 / dut_rdy  in  1 (DUT RDY/BSY, 1 = ready).

Function
REQ-012 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal not IDLE; cmd_valid while not ready SHALL be ignored.
REQ-013 States: IDLE, SETUP, PULSE, HOLD, WAIT_RDY, DONE; acceptance moves IDLE->SETUP.
REQ-014 Ops 0..3 (LOAD_CMD xa1/xa0/bs1=1/0/0, LOAD_ADDR_LO 0/0/0, LOAD_ADDR_HI 0/0/1, LOAD_DATA 0/1/0) SHALL drive those pins plus dut_data_out=cmd_data and dut_data_oe=1 from SETUP through HOLD, with dut_xtal=1 only in PULSE.
REQ-015 Op 4 LATCH_PAGE SHALL drive bs1=cmd_data[0] and dut_pagel=1 only in PULSE (XTAL_PULSE cycles).
REQ-016 Op 5 WRITE SHALL drive bs1=cmd_data[0], bs2=cmd_data[1], dut_wr=0 only in PULSE (WR_PULSE cycles), then enter WAIT_RDY.
REQ-017 WAIT_RDY SHALL ignore dut_rdy for its first 2 cycles, then go to DONE on the first cycle dut_rdy=1.
REQ-018 Ops 6/7 READ_LO/READ_HI SHALL drive bs1=0/1, bs2=cmd_data[0], dut_oe=0 in PULSE (OE_SETTLE cycles), latch dut_data_in into rsp_data on the last PULSE cycle, dut_oe=1 in HOLD.
REQ-019 SETUP and HOLD SHALL last exactly 1 cycle each; DONE SHALL last 1 cycle with rsp_valid=1, then IDLE.
REQ-020 Latency: for non-WRITE ops with pulse length N, rsp_valid SHALL be high in cycle N+3 after the acceptance edge and cmd_ready in cycle N+4.
REQ-021 dut_data_oe SHALL be 0 in every cycle dut_oe=0 (no bus contention), and 0 for ops 4..7.
REQ-022 Inactive levels outside an op: dut_oe=1, dut_wr=1, all other DUT controls 0.
REQ-023 rsp_data SHALL hold its value until the next read completes.
REQ-024 Pulse counter SHALL be 8 bit, loaded with N-1 on entering PULSE, exit at 0; no wrap.

Reset
REQ-025 rst SHALL force IDLE on the next edge from any state, aborting any op mid-pulse.
REQ-026 Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, error=0, dut_oe=1, dut_wr=1, dut_data_oe=0, dut_data_out=0, all other DUT controls 0.

Configuration
REQ-027 With AVR_PP_TIMEOUT_EN defined, WAIT_RDY exceeding RDY_TIMEOUT cycles SHALL set error=1 (sticky until rst) and go to DONE.
REQ-028 Without AVR_PP_TIMEOUT_EN, WAIT_RDY SHALL wait indefinitely, no timeout counter SHALL exist, and error SHALL be constant 0.

Verification
REQ-029 Op 0, data 0x40, defaults -> xa1=1, dut_data_out=0x40, dut_data_oe=1; dut_xtal high exactly 4 cycles; rsp_valid in cycle 7.
REQ-030 Op 6, dut_data_in=0xA5 -> dut_oe low 4 cycles, dut_data_oe=0 throughout, rsp_data=0xA5.
REQ-031 Op 5, dut_rdy low 10 cycles after pulse -> dut_wr low 8 cycles; rsp_valid only after dut_rdy returns to 1.
REQ-032 Op 5 with dut_rdy stuck 0, AVR_PP_TIMEOUT_EN defined, RDY_TIMEOUT=16 -> error=1, rsp_valid after timeout; without the macro, busy stays 1.
REQ-033 rst asserted during PULSE of op 4 -> next edge: dut_pagel=0, cmd_ready=1, no rsp_valid.
REQ-034 cmd_valid held high across back-to-back ops -> second op accepted only in the cycle cmd_ready=1, none lost or duplicated.

Source files
------------

// File: rtl/avr_pp_sequencer.sv
// avr_pp_sequencer: sequences AVR high-voltage parallel-programming pin waveforms
// (XTAL/PAGEL/WR/OE pulses, BS1/BS2/XA0/XA1 selects and the data bus) from a
// simple command handshake. All outputs are registered and aligned to the state
// they belong to.
// Optional feature macro: AVR_PP_TIMEOUT_EN enables the RDY/BSY timeout and the
// sticky error flag; without it WAIT_RDY waits indefinitely and error is 0.
module avr_pp_sequencer #(
  parameter int XTAL_PULSE  = 4,
  parameter int WR_PULSE    = 8,
  parameter int OE_SETTLE   = 4,
  parameter int RDY_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       error,
  output logic       busy,
  output logic       dut_xtal,
  output logic       dut_oe,
  output logic       dut_wr,
  output logic       dut_bs1,
  output logic       dut_bs2,
  output logic       dut_xa0,
  output logic       dut_xa1,
  output logic       dut_pagel,
  output logic [7:0] dut_data_out,
  output logic       dut_data_oe,
  input  logic [7:0] dut_data_in,
  input  logic       dut_rdy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD, ST_WAIT_RDY, ST_DONE
  } state_t;

  localparam logic [2:0] OP_LOAD_CMD     = 3'd0;
  localparam logic [2:0] OP_LOAD_ADDR_LO = 3'd1;
  localparam logic [2:0] OP_LOAD_ADDR_HI = 3'd2;
  localparam logic [2:0] OP_LOAD_DATA    = 3'd3;
  localparam logic [2:0] OP_LATCH_PAGE   = 3'd4;
  localparam logic [2:0] OP_WRITE        = 3'd5;
  localparam logic [2:0] OP_READ_LO      = 3'd6;
  localparam logic [2:0] OP_READ_HI      = 3'd7;

  typedef struct packed {
    logic       xtal;
    logic       oe;
    logic       wr;
    logic       bs1;
    logic       bs2;
    logic       xa0;
    logic       xa1;
    logic       pagel;
    logic       data_oe;
    logic [7:0] data_out;
  } pins_t;

  state_t     state_r, state_nx_s;
  logic [2:0] op_r, op_nx_s;
  logic [7:0] data_r, data_nx_s;
  logic [7:0] cnt_r, cnt_nx_s;
  logic       accept_s;
  logic       rdy_ok_s;
  logic       tmo_hit_s;
  pins_t      pins_nx_s;

  // Pulse length minus one, loaded into the pulse counter on entering PULSE.
  function automatic logic [7:0] pulse_len_m1(input logic [2:0] op);
    logic [7:0] n;
    case (op)
      OP_WRITE:               n = 8'(WR_PULSE - 1);
      OP_READ_LO, OP_READ_HI: n = 8'(OE_SETTLE - 1);
      default:                n = 8'(XTAL_PULSE - 1);
    endcase
    return n;
  endfunction

  // Pin levels for a given state/op; the bus is only driven by load ops, so it
  // is never enabled while OE is low.
  function automatic pins_t decode_pins(input state_t st, input logic [2:0] op,
                                        input logic [7:0] d);
    pins_t p;
    logic  act;
    logic  pul;
    p          = '0;
    p.oe       = 1'b1;
    p.wr       = 1'b1;
    act        = (st == ST_SETUP) || (st == ST_PULSE) || (st == ST_HOLD);
    pul        = (st == ST_PULSE);
    if (act) begin
      case (op)
        OP_LOAD_CMD:     begin p.xa1 = 1'b1; p.data_oe = 1'b1; p.data_out = d; p.xtal = pul; end
        OP_LOAD_ADDR_LO: begin p.data_oe = 1'b1; p.data_out = d; p.xtal = pul; end
        OP_LOAD_ADDR_HI: begin p.bs1 = 1'b1; p.data_oe = 1'b1; p.data_out = d; p.xtal = pul; end
        OP_LOAD_DATA:    begin p.xa0 = 1'b1; p.data_oe = 1'b1; p.data_out = d; p.xtal = pul; end
        OP_LATCH_PAGE:   begin p.bs1 = d[0]; p.pagel = pul; end
        OP_WRITE:        begin p.bs1 = d[0]; p.bs2 = d[1]; p.wr = ~pul; end
        OP_READ_LO:      begin p.bs1 = 1'b0; p.bs2 = d[0]; p.oe = ~pul; end
        OP_READ_HI:      begin p.bs1 = 1'b1; p.bs2 = d[0]; p.oe = ~pul; end
        default:         begin p.data_oe = 1'b0; end
      endcase
    end else begin
      p.data_oe = 1'b0;
    end
    return p;
  endfunction

  assign accept_s = cmd_valid & cmd_ready;
  assign rdy_ok_s = (state_r == ST_WAIT_RDY) && (cnt_r == 8'd0) && dut_rdy;

`ifdef AVR_PP_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;
  logic        error_r;

  assign tmo_hit_s = (state_r == ST_WAIT_RDY) && (tmo_cnt_r == 16'(RDY_TIMEOUT - 1));

  // Count WAIT_RDY cycles and latch the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 16'd0;
      error_r   <= 1'b0;
    end else begin
      if (state_r == ST_WAIT_RDY) tmo_cnt_r <= tmo_cnt_r + 16'd1;
      else                        tmo_cnt_r <= 16'd0;
      if (tmo_hit_s && !rdy_ok_s) error_r <= 1'b1;
      else                        error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign tmo_hit_s = 1'b0;
  // error never rises without the timeout feature (RDY_TIMEOUT is positive).
  assign error     = (RDY_TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Next-state, pulse-counter and next pin-level computation.
  always_comb begin
    state_nx_s = state_r;
    op_nx_s    = op_r;
    data_nx_s  = data_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_SETUP;
          op_nx_s    = cmd_op;
          data_nx_s  = cmd_data;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nx_s = ST_PULSE;
        cnt_nx_s   = pulse_len_m1(op_r);
      end
      ST_PULSE: begin
        if (cnt_r == 8'd0) begin
          if (op_r == OP_WRITE) begin
            state_nx_s = ST_WAIT_RDY;
            cnt_nx_s   = 8'd2;   // RDY is ignored for the first two WAIT_RDY cycles
          end else begin
            state_nx_s = ST_HOLD;
          end
        end else begin
          cnt_nx_s = cnt_r - 8'd1;
        end
      end
      ST_HOLD: state_nx_s = ST_DONE;
      ST_WAIT_RDY: begin
        if (cnt_r != 8'd0) cnt_nx_s = cnt_r - 8'd1;
        else               cnt_nx_s = cnt_r;
        if (rdy_ok_s || tmo_hit_s) state_nx_s = ST_DONE;
        else                       state_nx_s = ST_WAIT_RDY;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
    pins_nx_s = decode_pins(state_nx_s, op_nx_s, data_nx_s);
  end

  // State register plus registered handshake, response and DUT pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      op_r         <= 3'd0;
      data_r       <= 8'd0;
      cnt_r        <= 8'd0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'd0;
      dut_xtal     <= 1'b0;
      dut_oe       <= 1'b1;
      dut_wr       <= 1'b1;
      dut_bs1      <= 1'b0;
      dut_bs2      <= 1'b0;
      dut_xa0      <= 1'b0;
      dut_xa1      <= 1'b0;
      dut_pagel    <= 1'b0;
      dut_data_out <= 8'd0;
      dut_data_oe  <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      op_r         <= op_nx_s;
      data_r       <= data_nx_s;
      cnt_r        <= cnt_nx_s;
      cmd_ready    <= (state_nx_s == ST_IDLE);
      busy         <= (state_nx_s != ST_IDLE);
      rsp_valid    <= (state_nx_s == ST_DONE);
      if ((state_r == ST_PULSE) && (cnt_r == 8'd0) && (op_r[2:1] == 2'b11))
        rsp_data <= dut_data_in;
      else
        rsp_data <= rsp_data;
      dut_xtal     <= pins_nx_s.xtal;
      dut_oe       <= pins_nx_s.oe;
      dut_wr       <= pins_nx_s.wr;
      dut_bs1      <= pins_nx_s.bs1;
      dut_bs2      <= pins_nx_s.bs2;
      dut_xa0      <= pins_nx_s.xa0;
      dut_xa1      <= pins_nx_s.xa1;
      dut_pagel    <= pins_nx_s.pagel;
      dut_data_out <= pins_nx_s.data_out;
      dut_data_oe  <= pins_nx_s.data_oe;
    end
  end

endmodule
